// File: rtl/s2mm_pkg.sv
// ---------------------------------------------------------------------------
// s2mm_pkg
// Shared types for the S2MM/MM2S frame-buffer scheduler.
//   fb_idx_t   : 2-bit frame-buffer index (up to C_MAX_BUF buffers)
//   fb_state_t : writer control FSM states
//   idx_mask() : one-hot mask of a buffer index, used to build busy masks
// ---------------------------------------------------------------------------
package s2mm_pkg;

    localparam int C_MAX_BUF = 4;

    typedef logic [1:0] fb_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        STOP
    } fb_state_t;

    function automatic logic [C_MAX_BUF-1:0] idx_mask(input fb_idx_t idx);
        logic [C_MAX_BUF-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/fb_pick_next.sv
// ---------------------------------------------------------------------------
// fb_pick_next
// Combinational round-robin selector for the next write buffer.
// Ports:
//   start_idx : first index to consider; the scan wraps modulo C_BUF_NUM
//   busy_pref : buffers to avoid if any alternative exists (preferred tier)
//   busy_must : buffers that must never be chosen (fallback tier)
//   pick_idx  : first free index of the preferred tier, else of the fallback
//               tier; don't-care when none_free is set
//   none_free : every buffer is busy even in the fallback tier
// ---------------------------------------------------------------------------
module fb_pick_next
    import s2mm_pkg::*;
#(
    parameter int C_BUF_NUM = 3
)(
    input  fb_idx_t              start_idx,
    input  logic [C_MAX_BUF-1:0] busy_pref,
    input  logic [C_MAX_BUF-1:0] busy_must,
    output fb_idx_t              pick_idx,
    output logic                 none_free
);

    // cand[k] is the k-th index visited by the scan, free_*[k] its status.
    fb_idx_t              cand [C_BUF_NUM];
    logic [C_BUF_NUM-1:0] free_pref;
    logic [C_BUF_NUM-1:0] free_must;

    genvar gi;
    generate
        for (gi = 0; gi < C_BUF_NUM; gi++) begin : g_scan
            logic [2:0] sum;
            assign sum          = {1'b0, start_idx} + 3'(gi);
            // start_idx < C_BUF_NUM, so one conditional subtract is a full modulo
            assign cand[gi]     = (sum >= 3'(C_BUF_NUM)) ? fb_idx_t'(sum - 3'(C_BUF_NUM))
                                                         : sum[1:0];
            assign free_pref[gi] = ~busy_pref[cand[gi]];
            assign free_must[gi] = ~busy_must[cand[gi]];
        end
    endgenerate

    logic    pref_found;
    logic    must_found;
    fb_idx_t pref_idx;
    fb_idx_t must_idx;

    always_comb begin
        pref_found = 1'b0;
        must_found = 1'b0;
        pref_idx   = '0;
        must_idx   = '0;
        for (int k = 0; k < C_BUF_NUM; k++) begin
            if (!pref_found && free_pref[k]) begin
                pref_found = 1'b1;
                pref_idx   = cand[k];
            end
            if (!must_found && free_must[k]) begin
                must_found = 1'b1;
                must_idx   = cand[k];
            end
        end
    end

    assign pick_idx  = pref_found ? pref_idx : must_idx;
    assign none_free = ~must_found;

endmodule

// File: rtl/s2mm_fb_scheduler.sv
// ---------------------------------------------------------------------------
// s2mm_fb_scheduler
// Owns a ring of C_BUF_NUM DDR frame buffers. Supplies the S2MM writer's
// next base address, the MM2S reader's latest-complete-frame address, and
// sequences the writer's soft reset. Counts completed and overwritten frames.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   enable             : 1 = run the writer, 0 = stop it
//   buf_addr           : packed buffer base addresses, buffer i at [i*W +: W]
//   wr_soft_resetn     : writer soft reset (active low)
//   wr_resetting       : writer reports its reset in progress
//   wr_frame_pulse     : writer wrapped to a new frame
//   wr_base_addr       : address the writer takes at its next wrap
//   rd_frame_pulse     : reader latched rd_base_addr for a new frame
//   rd_base_addr       : address of the latest completed frame
//   rd_valid           : a completed frame exists since start
//   frame_cnt/drop_cnt : saturating completed-frame / overwrite counters
// ---------------------------------------------------------------------------
module s2mm_fb_scheduler
    import s2mm_pkg::*;
#(
    parameter int C_BUF_NUM    = 3,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_CNT_BITS   = 16
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [C_BUF_NUM*C_ADDR_WIDTH-1:0] buf_addr,
    output logic                              wr_soft_resetn,
    input  logic                              wr_resetting,
    input  logic                              wr_frame_pulse,
    output logic [C_ADDR_WIDTH-1:0]           wr_base_addr,
    input  logic                              rd_frame_pulse,
    output logic [C_ADDR_WIDTH-1:0]           rd_base_addr,
    output logic                              rd_valid,
    output logic [C_CNT_BITS-1:0]             frame_cnt,
    output logic [C_CNT_BITS-1:0]             drop_cnt
);

    localparam fb_idx_t LAST_IDX = fb_idx_t'(C_BUF_NUM - 1);

    function automatic logic [C_CNT_BITS-1:0] sat_inc(input logic [C_CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Address lookup padded to C_MAX_BUF entries so a 2-bit index always fits.
    logic [C_ADDR_WIDTH-1:0] addr_tbl [C_MAX_BUF];

    genvar gi;
    generate
        for (gi = 0; gi < C_MAX_BUF; gi++) begin : g_addr
            if (gi < C_BUF_NUM) begin : g_used
                assign addr_tbl[gi] = buf_addr[gi*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            end else begin : g_unused
                assign addr_tbl[gi] = '0;
            end
        end
    endgenerate

    fb_state_t               state_reg,      state_next;
    fb_idx_t                 cur_w_reg,      cur_w_next;
    fb_idx_t                 nxt_w_reg,      nxt_w_next;
    fb_idx_t                 latest_reg,     latest_next;
    fb_idx_t                 rd_cur_reg,     rd_cur_next;
    logic                    latest_v_reg,   latest_v_next;
    logic                    rd_v_reg,       rd_v_next;
    logic                    primed_reg,     primed_next;   // initial wrap from address 0 seen
    logic                    rst_ok_reg,     rst_ok_next;   // one idle wr_resetting sample seen in STOP
    logic [C_CNT_BITS-1:0]   frame_cnt_reg,  frame_cnt_next;
    logic [C_CNT_BITS-1:0]   drop_cnt_reg,   drop_cnt_next;
    logic                    wr_soft_resetn_reg;
    logic [C_ADDR_WIDTH-1:0] wr_base_addr_reg;
    logic [C_ADDR_WIDTH-1:0] rd_base_addr_reg;
    logic                    rd_valid_reg;

    // Writer update first, then reader latch on the updated view, so a
    // same-cycle reader pulse grabs the frame that just completed and the
    // next-target scan already excludes it.
    logic                 wrap;
    fb_idx_t              cur_new;
    fb_idx_t              latest_new;
    fb_idx_t              rd_cur_new;
    fb_idx_t              scan_start;
    logic                 latest_v_new;
    logic                 rd_v_new;
    logic [C_MAX_BUF-1:0] busy_pref;
    logic [C_MAX_BUF-1:0] busy_must;
    fb_idx_t              pick_idx;
    logic                 none_free;

    always_comb begin
        wrap         = wr_frame_pulse && (state_reg == RUN);
        cur_new      = cur_w_reg;
        latest_new   = latest_reg;
        latest_v_new = latest_v_reg;
        if (wrap) begin
            cur_new = nxt_w_reg;
            if (primed_reg) begin
                latest_new   = cur_w_reg;
                latest_v_new = 1'b1;
            end
        end

        rd_cur_new = rd_cur_reg;
        rd_v_new   = rd_v_reg;
        if (rd_frame_pulse && latest_v_new) begin
            rd_cur_new = latest_new;
            rd_v_new   = 1'b1;
        end

        busy_must = idx_mask(cur_new);
        if (rd_v_new) begin
            busy_must = busy_must | idx_mask(rd_cur_new);
        end
        busy_pref = busy_must;
        if (latest_v_new) begin
            busy_pref = busy_pref | idx_mask(latest_new);
        end

        scan_start = (nxt_w_reg == LAST_IDX) ? fb_idx_t'(0) : nxt_w_reg + 1'b1;
    end

    fb_pick_next #(
        .C_BUF_NUM (C_BUF_NUM)
    ) u_pick (
        .start_idx (scan_start),
        .busy_pref (busy_pref),
        .busy_must (busy_must),
        .pick_idx  (pick_idx),
        .none_free (none_free)
    );

    always_comb begin
        state_next     = state_reg;
        cur_w_next     = cur_new;
        nxt_w_next     = nxt_w_reg;
        latest_next    = latest_new;
        latest_v_next  = latest_v_new;
        rd_cur_next    = rd_cur_new;
        rd_v_next      = rd_v_new;
        primed_next    = primed_reg;
        rst_ok_next    = rst_ok_reg;
        frame_cnt_next = frame_cnt_reg;
        drop_cnt_next  = drop_cnt_reg;

        if (wrap) begin
            primed_next = 1'b1;
            if (primed_reg) begin
                frame_cnt_next = sat_inc(frame_cnt_reg);
            end
            // No free buffer: keep writing over the current one.
            if (none_free) begin
                nxt_w_next    = cur_new;
                drop_cnt_next = sat_inc(drop_cnt_reg);
            end else begin
                nxt_w_next = pick_idx;
            end
        end

        case (state_reg)
            IDLE: begin
                if (enable && !wr_resetting) begin
                    state_next = START;
                end
            end
            START: begin
                cur_w_next     = fb_idx_t'(0);
                nxt_w_next     = fb_idx_t'(1);
                latest_v_next  = 1'b0;
                rd_v_next      = 1'b0;
                primed_next    = 1'b0;
                frame_cnt_next = '0;
                drop_cnt_next  = '0;
                state_next     = RUN;
            end
            RUN: begin
                rst_ok_next = 1'b0;
                if (!enable) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                rst_ok_next = !wr_resetting;
                if (!wr_resetting && rst_ok_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            cur_w_reg          <= '0;
            nxt_w_reg          <= '0;
            latest_reg         <= '0;
            rd_cur_reg         <= '0;
            latest_v_reg       <= 1'b0;
            rd_v_reg           <= 1'b0;
            primed_reg         <= 1'b0;
            rst_ok_reg         <= 1'b0;
            frame_cnt_reg      <= '0;
            drop_cnt_reg       <= '0;
            wr_soft_resetn_reg <= 1'b0;
            wr_base_addr_reg   <= addr_tbl[0];
            rd_base_addr_reg   <= addr_tbl[0];
            rd_valid_reg       <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cur_w_reg          <= cur_w_next;
            nxt_w_reg          <= nxt_w_next;
            latest_reg         <= latest_next;
            rd_cur_reg         <= rd_cur_next;
            latest_v_reg       <= latest_v_next;
            rd_v_reg           <= rd_v_next;
            primed_reg         <= primed_next;
            rst_ok_reg         <= rst_ok_next;
            frame_cnt_reg      <= frame_cnt_next;
            drop_cnt_reg       <= drop_cnt_next;
            wr_soft_resetn_reg <= (state_next == RUN);
            wr_base_addr_reg   <= addr_tbl[nxt_w_next];
            rd_base_addr_reg   <= addr_tbl[latest_next];
            rd_valid_reg       <= latest_v_next;
        end
    end

    assign wr_soft_resetn = wr_soft_resetn_reg;
    assign wr_base_addr   = wr_base_addr_reg;
    assign rd_base_addr   = rd_base_addr_reg;
    assign rd_valid       = rd_valid_reg;
    assign frame_cnt      = frame_cnt_reg;
    assign drop_cnt       = drop_cnt_reg;

endmodule

// File: doc/s2mm_fb_scheduler.md
# s2mm_fb_scheduler

Frame-buffer scheduler for the S2MM/MM2S video path. It owns a ring of 2–4 DDR frame buffers and supplies the FIFO-to-memory writer's `base_addr`. It also supplies the base address of the most recently completed frame to the memory-to-FIFO reader, so the writer never overwrites the buffer the reader is scanning. It sequences the writer's soft reset on enable/disable and keeps frame and drop statistics.

## Interface
- `C_BUF_NUM`, 3 — number of frame buffers, 2..4.
- `C_ADDR_WIDTH`, 32 — AXI address width.
- `C_CNT_BITS`, 16 — width of the statistics counters.

Ports (clock and reset first):
- `clk`  in  1  — single clock, same domain as the writer's AXI clock.
- `reset`  in  1  — synchronous, active-high reset.
- `enable`  in  1  — level; 1 = run the writer, 0 = stop it.
- `buf_addr`  in  C_BUF_NUM*C_ADDR_WIDTH  — buffer i base address at bits [i*W +: W]. Each address is 4 KiB aligned. Static while `enable`=1.
- `wr_soft_resetn`  out  1  — drives the writer's `soft_resetn`.
- `wr_resetting`  in  1  — the writer's `resetting`.
- `wr_frame_pulse`  in  1  — the writer's `frame_pulse`: a one-cycle pulse when the writer wraps to a new frame.
- `wr_base_addr`  out  C_ADDR_WIDTH  — address the writer will use at its next wrap.
- `rd_frame_pulse`  in  1  — one-cycle pulse when the reader latches `rd_base_addr` for a new frame.
- `rd_base_addr`  out  C_ADDR_WIDTH  — address of the latest completed frame.
- `rd_valid`  out  1  — at least one complete frame exists since the start.
- `frame_cnt`, `drop_cnt`  out  C_CNT_BITS each — completed-frame count and overwrite count.

## Operation
- State is held as indices, each 2 bits wide: `cur_w` (being written), `nxt_w` (next write target), `latest` (last complete), `rd_cur` (held by the reader). Flags `latest_v` and `rd_v` mark `latest` and `rd_cur` as valid.
- Control FSM states:
  - IDLE: `wr_soft_resetn`=0. Go to START when `enable`=1 and `wr_resetting`=0.
  - START: load `cur_w`=0, `nxt_w`=1, clear `latest_v`, `rd_v` and the counters. Go to RUN next cycle.
  - RUN: `wr_soft_resetn`=1. If `enable`=0, go to STOP.
  - STOP: `wr_soft_resetn`=0. Go to IDLE once `wr_resetting`=0 has been sampled for 2 consecutive cycles.
- Writer wrap, on `wr_frame_pulse` in RUN:
  - Update `latest`←`cur_w`, set `latest_v`=1, `cur_w`←`nxt_w`, increment `frame_cnt`.
  - Choose the new `nxt_w` by scanning round-robin from `nxt_w`+1 (mod C_BUF_NUM).
  - First choice: the first index not in {new `cur_w`, `rd_cur` if `rd_v`, new `latest`}.
  - Else: the first index not in {new `cur_w`, `rd_cur` if `rd_v`}.
  - Else: `nxt_w`=new `cur_w` and increment `drop_cnt`. This case occurs only with C_BUF_NUM=2 while the reader holds the other buffer.
  - Ignore `wr_frame_pulse` outside RUN.
- The very first `wr_frame_pulse` after START corresponds to the writer's initial wrap from address 0. It only sets `cur_w`←`nxt_w`; it does not set `latest_v` or increment `frame_cnt`.
- Reader latch, on `rd_frame_pulse`: if `latest_v`, set `rd_cur`←`latest` and `rd_v`=1. Otherwise ignore it.
- Simultaneous pulses: the writer update is applied first. The reader then latches the newly updated `latest`, and the `nxt_w` exclusion uses the new `rd_cur`.
- Counters saturate at all-ones.

## Timing
- Reset values:
  - `wr_soft_resetn`=0, `rd_valid`=0, counters 0.
  - `wr_base_addr`=`buf_addr[0]`, `rd_base_addr`=`buf_addr[0]`.
  - FSM in IDLE.
- All outputs are registered.
- `wr_base_addr` = `buf_addr[nxt_w]`, valid 1 cycle after the `wr_frame_pulse` cycle. The writer's next sample is at least one burst later.
- `rd_base_addr` = `buf_addr[latest]` and `rd_valid` = `latest_v`, both updated 1 cycle after the pulse.
- `enable` falling edge → `wr_soft_resetn`=0 on the next cycle.
- `reset` mid-frame → all state returns to its reset values on the next cycle, regardless of `wr_resetting`.

## Structure
- Shared package `s2mm_pkg`:
  - `fb_idx_t` (2-bit index type).
  - State enum `{IDLE, START, RUN, STOP}`.
  - `C_MAX_BUF`=4.
- Sub-module `fb_pick_next`: combinational round-robin selector. Inputs: start index and a busy mask for each exclusion tier. Outputs: chosen index and a `none_free` flag.

## Test plan
- Start-up, C_BUF_NUM=3, addrs 0x1000_0000/0x1010_0000/0x1020_0000:
  - Assert `enable` → `wr_soft_resetn`=1 two cycles later and `wr_base_addr`=0x1010_0000.
  - After the first pulse, `rd_valid` is still 0.
- Triple buffering: 5 writer pulses with no reader pulse → `nxt_w` cycles 2,0,1,2,0 and `frame_cnt`=4.
- Reader hold: reader latches buffer 1 and then 6 writer pulses follow → `nxt_w` is never 1 and `drop_cnt`=0.
- C_BUF_NUM=2 with the reader holding buffer 1 → the writer re-targets `cur_w` and `drop_cnt` increments on each pulse.
- Same-cycle writer and reader pulses → `rd_base_addr` equals the buffer just completed, and `nxt_w`≠`rd_cur`.
- Drop `enable` mid-frame with `wr_resetting` held high for 20 cycles → FSM stays in STOP, then returns to IDLE 2 cycles after `wr_resetting` falls.
- `reset` pulsed in RUN → all outputs return to their reset values on the next cycle.
